// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: control bundle layout, opcodes and
// the ALU / writeback / jump encodings carried in that bundle.
package id_pkg;

    localparam int CTRL_W = 13;

    // Bit positions of each field inside the 13-bit controls bundle
    localparam int C_MEM_READ  = 12;
    localparam int C_MEM_WRITE = 11;
    localparam int C_ALU_SRC_A = 10;
    localparam int C_ALU_SRC_B = 9;
    localparam int C_M2R_HI    = 8;
    localparam int C_M2R_LO    = 7;
    localparam int C_ALU_HI    = 6;
    localparam int C_ALU_LO    = 3;
    localparam int C_REG_WRITE = 2;
    localparam int C_JUMP_HI   = 1;
    localparam int C_JUMP_LO   = 0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        M2R_ALU = 2'd0,
        M2R_MEM = 2'd1,
        M2R_PC4 = 2'd2
    } m2r_e;

    typedef enum logic [1:0] {
        JMP_NONE   = 2'd0,
        JMP_BRANCH = 2'd1,
        JMP_JAL    = 2'd2,
        JMP_JALR   = 2'd3
    } jump_e;

    // Field order matches the bit-index constants above (MSB first)
    typedef struct packed {
        logic    mem_read;
        logic    mem_write;
        logic    alu_src_a;
        logic    alu_src_b;
        m2r_e    mem_to_reg;
        alu_op_e alu_op;
        logic    reg_write;
        jump_e   jump;
    } ctrl_t;

    // funct7 bit 5 selects SUB only for register-register ops; shifts use it for both
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7_b5,
                                               input logic       is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_control.sv
// RV32I main control decoder: opcode/funct fields to the 13-bit control bundle.
// Latency: combinational; backpressure: none (pure function of its inputs).
module id_control
    import id_pkg::*;
(
    input  logic              arst_n,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7_b5,
    output logic [CTRL_W-1:0] controls,
    output logic [1:0]        inst_size,
    output logic              is_signed
);

    ctrl_t ctrl;

    always_comb begin
        ctrl      = '0;
        inst_size = 2'b00;
        is_signed = 1'b0;
        if (arst_n) begin
            case (opcode)
                OPC_LOAD: begin
                    ctrl.mem_read   = 1'b1;
                    ctrl.alu_src_b  = 1'b1;
                    ctrl.mem_to_reg = M2R_MEM;
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.reg_write  = 1'b1;
                    inst_size       = funct3[1:0];
                    is_signed       = ~funct3[2];
                end
                OPC_STORE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_src_b = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                    inst_size      = funct3[1:0];
                end
                OPC_BRANCH: begin
                    ctrl.alu_op = ALU_SUB;
                    ctrl.jump   = JMP_BRANCH;
                end
                OPC_JAL: begin
                    ctrl.alu_src_a  = 1'b1;
                    ctrl.alu_src_b  = 1'b1;
                    ctrl.mem_to_reg = M2R_PC4;
                    ctrl.reg_write  = 1'b1;
                    ctrl.jump       = JMP_JAL;
                end
                OPC_JALR: begin
                    ctrl.alu_src_b  = 1'b1;
                    ctrl.mem_to_reg = M2R_PC4;
                    ctrl.reg_write  = 1'b1;
                    ctrl.jump       = JMP_JALR;
                end
                OPC_OP: begin
                    ctrl.alu_op    = alu_from_funct(funct3, funct7_b5, 1'b1);
                    ctrl.reg_write = 1'b1;
                end
                OPC_OP_IMM: begin
                    ctrl.alu_src_b = 1'b1;
                    ctrl.alu_op    = alu_from_funct(funct3, funct7_b5, 1'b0);
                    ctrl.reg_write = 1'b1;
                end
                OPC_LUI: begin
                    ctrl.alu_src_b = 1'b1;
                    ctrl.alu_op    = ALU_PASSB;
                    ctrl.reg_write = 1'b1;
                end
                OPC_AUIPC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.reg_write = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign controls = ctrl;

endmodule

// File: rtl/id_hazard_unit.sv
// Load-use detector: a valid load in ID/EX whose rd matches the incoming rs1/rs2.
// Latency: combinational; backpressure: none (the stage turns hazard into a bubble).
module id_hazard_unit #(
    parameter int HAZARD_EN = 1
) (
    input  logic       ex_vld,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_vld,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hazard
);

    generate
        if (HAZARD_EN != 0) begin : g_hazard
            // rs2 is compared for every format; a false match only costs one bubble
            assign hazard = ex_vld && ex_mem_read && (ex_rd != 5'd0) && id_vld &&
                            ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
        end else begin : g_no_hazard
            assign hazard = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/id_sign_extend.sv
// RV32I immediate generator for I/S/B/U/J formats, sign-extended to 32 bits.
// Latency: combinational; backpressure: none. Formats without an immediate give 0.
module id_sign_extend
    import id_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {inst[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage owning the ID/EX register. Latency: 1 cycle accept-to-out_valid;
// backpressure: holds ID/EX while out_ready=0, load-use inserts one bubble, flush drops input.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int HAZARD_EN   = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            inst,
    input  logic [XLEN-1:0]        pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      controls,
    output logic [1:0]             inst_size,
    output logic                   is_signed,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic [XLEN-1:0]        imm,
    output logic [XLEN-1:0]        pc_out,
    output logic [XLEN-1:0]        branch_addr,
    output logic                   hazard_stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [CTRL_W-1:0] dec_controls;
    logic [1:0]        dec_size;
    logic              dec_signed;
    logic [31:0]       dec_imm32;
    logic [XLEN-1:0]   dec_imm;
    logic [XLEN-1:0]   dec_branch;
    logic [4:0]        dec_rs1;
    logic [4:0]        dec_rs2;
    logic [4:0]        dec_rd;
    logic              hazard;
    logic              advance;
    logic              accept;

    assign dec_rs1 = inst[19:15];
    assign dec_rs2 = inst[24:20];
    assign dec_rd  = inst[11:7];

    id_control u_control (
        .arst_n    (1'b1),
        .opcode    (inst[6:0]),
        .funct3    (inst[14:12]),
        .funct7_b5 (inst[30]),
        .controls  (dec_controls),
        .inst_size (dec_size),
        .is_signed (dec_signed)
    );

    id_sign_extend u_sign_extend (
        .inst (inst),
        .imm  (dec_imm32)
    );

    // Bit 31 of the 32-bit immediate is the sign for every format, U-type included
    assign dec_imm    = XLEN'($signed(dec_imm32));
    assign dec_branch = pc + dec_imm;

    id_hazard_unit #(
        .HAZARD_EN (HAZARD_EN)
    ) u_hazard (
        .ex_vld      (out_valid),
        .ex_mem_read (controls[C_MEM_READ]),
        .ex_rd       (rd),
        .id_vld      (in_valid),
        .id_rs1      (dec_rs1),
        .id_rs2      (dec_rs2),
        .hazard      (hazard)
    );

    assign advance      = !out_valid || out_ready;
    assign in_ready     = advance && !hazard && !flush;
    assign accept       = in_valid && in_ready;
    // A flushed cycle inserts no load-use bubble, so it is neither flagged nor counted
    assign hazard_stall = hazard && advance && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            controls    <= '0;
            inst_size   <= '0;
            is_signed   <= 1'b0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            imm         <= '0;
            pc_out      <= '0;
            branch_addr <= '0;
            stall_count <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
                controls  <= '0;
            end else if (advance) begin
                if (accept) begin
                    out_valid   <= 1'b1;
                    controls    <= dec_controls;
                    inst_size   <= dec_size;
                    is_signed   <= dec_signed;
                    rs1         <= dec_rs1;
                    rs2         <= dec_rs2;
                    rd          <= dec_rd;
                    imm         <= dec_imm;
                    pc_out      <= pc;
                    branch_addr <= dec_branch;
                end else begin
                    // Bubble or idle slot: nothing valid, no side effects downstream
                    out_valid <= 1'b0;
                    controls  <= '0;
                end
            end

            if (hazard_stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
                stall_count <= stall_count + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: table of single-instruction decodes plus
// load-use, x0 load, back-pressure/flush, counter saturation and mid-stream reset sequences.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, is_signed, hazard_stall;
    logic [12:0] controls;
    logic [1:0]  inst_size;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc_out, branch_addr;
    logic [15:0] stall_count;

    logic        in_ready_b, out_valid_b, is_signed_b, hazard_stall_b;
    logic [12:0] controls_b;
    logic [1:0]  inst_size_b;
    logic [4:0]  rs1_b, rs2_b, rd_b;
    logic [31:0] imm_b, pc_out_b, branch_addr_b;
    logic [1:0]  stall_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] LW_X5  = 32'h0000A283;
    localparam logic [31:0] ADD_X5 = 32'h00228333;
    localparam logic [31:0] LW_X0  = 32'h0000A003;
    localparam logic [31:0] ADD_X0 = 32'h00200333;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .HAZARD_EN(1), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .controls(controls), .inst_size(inst_size),
        .is_signed(is_signed), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .pc_out(pc_out), .branch_addr(branch_addr), .hazard_stall(hazard_stall),
        .stall_count(stall_count)
    );

    id_stage_pipe #(.XLEN(32), .HAZARD_EN(1), .STALL_CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .inst(inst), .pc(pc), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .controls(controls_b), .inst_size(inst_size_b),
        .is_signed(is_signed_b), .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .imm(imm_b),
        .pc_out(pc_out_b), .branch_addr(branch_addr_b), .hazard_stall(hazard_stall_b),
        .stall_count(stall_count_b)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [12:0] ctl;
        logic [31:0] imm;
        logic [31:0] br;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  size;
        logic        sgn;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // lw x5 then dependent add: one bubble, then the add lands in ID/EX
    task automatic load_use(input logic [15:0] exp_cnt, input logic [1:0] exp_sat);
        inst = LW_X5; pc = 32'h40; in_valid = 1'b1;
        #1;
        chk("lu_lw_in_ready", in_ready, 1);
        step();
        chk("lu_lw_valid", out_valid, 1);
        chk("lu_lw_ctl", controls, 13'h1284);
        inst = ADD_X5; pc = 32'h44;
        #1;
        chk("lu_hazard_stall", hazard_stall, 1);
        chk("lu_in_ready_low", in_ready, 0);
        step();
        chk("lu_bubble_valid", out_valid, 0);
        chk("lu_bubble_ctl", controls, 0);
        chk("lu_stall_clear", hazard_stall, 0);
        chk("lu_add_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("lu_add_valid", out_valid, 1);
        chk("lu_add_rd", rd, 6);
        chk("lu_stall_count", stall_count, exp_cnt);
        chk("lu_stall_count_sat", stall_count_b, exp_sat);
    endtask

    initial begin
        vecs[0]  = '{32'h00000463, 32'h100,  13'h009,  32'h00000008, 32'h00000108, 5'd8,  5'd0,  5'd0,  2'd0, 1'b0};
        vecs[1]  = '{32'h0000A283, 32'h200,  13'h1284, 32'h00000000, 32'h00000200, 5'd5,  5'd1,  5'd0,  2'd2, 1'b1};
        vecs[2]  = '{32'hFFF10093, 32'h300,  13'h204,  32'hFFFFFFFF, 32'h000002FF, 5'd1,  5'd2,  5'd31, 2'd0, 1'b0};
        vecs[3]  = '{32'h00512423, 32'h400,  13'hA00,  32'h00000008, 32'h00000408, 5'd8,  5'd2,  5'd5,  2'd2, 1'b0};
        vecs[4]  = '{32'h123451B7, 32'h0,    13'h254,  32'h12345000, 32'h12345000, 5'd3,  5'd8,  5'd3,  2'd0, 1'b0};
        vecs[5]  = '{32'hFFDFF0EF, 32'h1000, 13'h706,  32'hFFFFFFFC, 32'h00000FFC, 5'd1,  5'd31, 5'd29, 2'd0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'h500,  13'h000,  32'h00000000, 32'h00000500, 5'd31, 5'd31, 5'd31, 2'd0, 1'b0};
        vecs[7]  = '{32'h409403B3, 32'h600,  13'h00C,  32'h00000000, 32'h00000600, 5'd7,  5'd8,  5'd9,  2'd0, 1'b0};
        vecs[8]  = '{32'h0030C203, 32'h700,  13'h1284, 32'h00000003, 32'h00000703, 5'd4,  5'd1,  5'd3,  2'd0, 1'b0};
        vecs[9]  = '{32'h00008067, 32'h800,  13'h307,  32'h00000000, 32'h00000800, 5'd0,  5'd1,  5'd0,  2'd0, 1'b0};
        vecs[10] = '{32'hFFFFF297, 32'h2000, 13'h604,  32'hFFFFF000, 32'h00001000, 5'd5,  5'd31, 5'd31, 2'd0, 1'b0};
        vecs[11] = '{32'h40315093, 32'h900,  13'h23C,  32'h00000403, 32'h00000D03, 5'd1,  5'd2,  5'd3,  2'd0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; inst = '0; pc = '0; flush = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_controls", controls, 0);
        chk("rst_stall_count", stall_count, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            inst = vecs[i].inst; pc = vecs[i].pc; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_controls", i), controls, vecs[i].ctl);
            chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("v%0d_branch_addr", i), branch_addr, vecs[i].br);
            chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].pc);
            chk($sformatf("v%0d_regs", i), {rd, rs1, rs2}, {vecs[i].rd, vecs[i].rs1, vecs[i].rs2});
            chk($sformatf("v%0d_size_signed", i), {inst_size, is_signed}, {vecs[i].size, vecs[i].sgn});
            step();
        end

        reset = 1'b1;
        step();
        reset = 1'b0;
        load_use(16'd1, 2'd1);

        // Load to x0 never interlocks
        inst = LW_X0; pc = 32'h80; in_valid = 1'b1;
        step();
        chk("x0_lw_valid", out_valid, 1);
        chk("x0_lw_rd", rd, 0);
        inst = ADD_X0; pc = 32'h84;
        #1;
        chk("x0_no_stall", hazard_stall, 0);
        chk("x0_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("x0_add_rd", rd, 6);
        chk("x0_stall_count", stall_count, 1);

        load_use(16'd2, 2'd2);
        load_use(16'd3, 2'd3);
        load_use(16'd4, 2'd3);
        load_use(16'd5, 2'd3);

        // Reset while a valid instruction sits in ID/EX with a non-zero count
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_controls", controls, 0);
        chk("mid_rst_imm", imm, 0);
        chk("mid_rst_stall_count", stall_count, 0);
        chk("mid_rst_stall_count_sat", stall_count_b, 0);

        // Back-pressure with a load held, flush in the middle
        inst = LW_X5; pc = 32'h40; in_valid = 1'b1;
        step();
        chk("bp_lw_valid", out_valid, 1);
        out_ready = 1'b0;
        inst = ADD_X5; pc = 32'h44;
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_no_stall", hazard_stall, 0);
        step();
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_ctl", controls, 13'h1284);
        chk("bp_hold_rd", rd, 5);
        chk("bp_hold_pc", pc_out, 32'h40);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_stall_count", stall_count, 0);
        step();
        chk("fl_add_after_valid", out_valid, 1);
        chk("fl_add_after_rd", rd, 6);
        chk("fl_add_after_count", stall_count, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
